// File: rtl/rca_accumulator_4_pkg.sv
// Shared definitions for the rca_4 based operand accumulator:
// FSM state encoding and datapath width.
package rca_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/rca_accumulator_4_if.sv
// Operand-in / result-out handshake bundle of rca_accumulator_4.
// The master modport is the operand source and result consumer side.
interface rca_accumulator_4_if;
   import rca_pkg::*;

   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_sum;
   logic              out_carry;
   logic              busy;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, busy
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_carry, busy
   );

endinterface

// File: rtl/rca_accumulator_4_rca_4.sv
// Existing 4-bit ripple-carry adder: a chain of full adders, carry-in tied low.
module rca_4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] SUM,
   output logic       CARRY
);

   logic [4:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign SUM[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign CARRY = c[4];

endmodule

// File: rtl/rca_accumulator_4.sv
// Accumulates a burst of N_OPS unsigned operands through rca_4 and presents the
// modulo-16 sum plus a sticky carry flag on a valid/ready result handshake.
module rca_accumulator_4
   import rca_pkg::*;
#(
   parameter int N_OPS = 4   // operands per accumulation, 1..15
) (
   input  logic                 clk,
   input  logic                 rst,
   rca_accumulator_4_if.slave   bus
);

   localparam logic [3:0] LAST = 4'(N_OPS - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic              ovf, ovf_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [DATA_W-1:0] sum;
   logic              carry;
   logic              accept;

   rca_4 u_rca_4 (
      .A     (acc),
      .B     (bus.in_data),
      .SUM   (sum),
      .CARRY (carry)
   );

   assign accept = (state == ACCUM) && bus.in_valid;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      ovf_nxt   = ovf;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            // start wins over a simultaneous operand; nothing is accepted here
            if (bus.start) begin
               acc_nxt   = '0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nxt = sum;
               ovf_nxt = ovf | carry;
               cnt_nxt = cnt + 4'd1;
               if (cnt == LAST) state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         ovf   <= ovf_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Handshake outputs decode the state register only
   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == ACCUM) || (state == DONE);
   assign bus.out_sum   = acc;
   assign bus.out_carry = ovf;

endmodule
